// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control sequencer:
// opcodes, FSM states, datapath select codes, halt causes and the control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RFMT = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h31;
  localparam logic [5:0] OP_SW   = 6'h35;
  localparam logic [5:0] OP_BEQ  = 6'h08;
  localparam logic [5:0] OP_BNE  = 6'h37;
  localparam logic [5:0] OP_JMP  = 6'h21;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_R_WB,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WB,
    ST_MEM_WR,
    ST_BRANCH,
    ST_JUMP,
    ST_HALT
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_JUMP  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] HALT_NONE    = 2'b00;
  localparam logic [1:0] HALT_ILLEGAL = 2'b01;
  localparam logic [1:0] HALT_TIMEOUT = 2'b10;

  typedef struct packed {
    logic r;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic jmp;
  } op_class_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_beq;
    logic       pc_write_bne;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the sequencer and the shared datapath/memory.
// master = sequencer side, slave = datapath side.
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             mem_read;
  logic             mem_write;
  logic             i_or_d;
  logic             ir_write;
  logic             pc_write;
  logic             pc_write_beq;
  logic             pc_write_bne;
  logic [1:0]       pc_source;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             halted;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_beq,
           pc_write_bne, pc_source, alu_src_a, alu_src_b, alu_op, reg_dst,
           mem_to_reg, reg_write, halted, halt_cause, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_beq,
           pc_write_bne, pc_source, alu_src_a, alu_src_b, alu_op, reg_dst,
           mem_to_reg, reg_write, halted, halt_cause, instr_count
  );
endinterface

// File: rtl/opcode_class_decode.sv
// Maps the 6-bit opcode onto a one-hot instruction class; no class hit means illegal.
module opcode_class_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  cls,
  output logic       illegal
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RFMT: cls.r   = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_BNE:  cls.bne = 1'b1;
      OP_JMP:  cls.jmp = 1'b1;
      default: cls = '0;
    endcase
    illegal = (cls == '0);
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with a bounded
// memory handshake wait, sticky halt and a retired-instruction counter.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_control_fsm_if.master bus
);

  localparam int                WCNT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  instr_count_q, instr_count_d;
  logic [1:0]        halt_cause_q, halt_cause_d;

  op_class_t dec_cls;
  logic      dec_illegal;
  ctrl_t     ctrl;
  ctrl_t     ctrl_o;
  logic      mem_wait;
  logic      retire;

  opcode_class_decode u_opcode_class_decode (
    .opcode  (bus.opcode),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      wait_cnt_q    <= '0;
      instr_count_q <= '0;
      halt_cause_q  <= HALT_NONE;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      instr_count_q <= instr_count_d;
      halt_cause_q  <= halt_cause_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    halt_cause_d = halt_cause_q;
    ctrl         = '0;
    mem_wait     = 1'b0;
    retire       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        mem_wait       = 1'b1;
        if (bus.mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Speculatively form the branch target while the opcode is decoded.
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
        if (dec_illegal) begin
          state_d      = ST_HALT;
          halt_cause_d = HALT_ILLEGAL;
        end else if (dec_cls.r) begin
          state_d = ST_EXEC_R;
        end else if (dec_cls.lw || dec_cls.sw) begin
          state_d = ST_MEM_ADDR;
        end else if (dec_cls.beq || dec_cls.bne) begin
          state_d = ST_BRANCH;
        end else if (dec_cls.jmp) begin
          state_d = ST_JUMP;
        end
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALU_FUNCT;
        state_d        = ST_R_WB;
      end
      ST_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        retire         = 1'b1;
        state_d        = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_d        = dec_cls.sw ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        mem_wait      = 1'b1;
        if (bus.mem_ready) state_d = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.reg_write  = 1'b1;
        retire          = 1'b1;
        state_d         = ST_FETCH;
      end
      ST_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        mem_wait       = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_BRANCH: begin
        ctrl.alu_src_a    = 1'b1;
        ctrl.alu_src_b    = SRCB_REGB;
        ctrl.alu_op       = ALU_SUB;
        ctrl.pc_source    = PCSRC_ALUOUT;
        ctrl.pc_write_beq = dec_cls.beq;
        ctrl.pc_write_bne = dec_cls.bne;
        retire            = 1'b1;
        state_d           = ST_FETCH;
      end
      ST_JUMP: begin
        ctrl.alu_op    = ALU_JUMP;
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
        retire         = 1'b1;
        state_d        = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase

    // A ready in the final allowed wait cycle still completes the access.
    if (mem_wait && !bus.mem_ready) begin
      if (wait_cnt_q == WAIT_LAST) begin
        state_d      = ST_HALT;
        halt_cause_d = HALT_TIMEOUT;
      end else begin
        wait_cnt_d = wait_cnt_q + WCNT_W'(1);
      end
    end

    if ((state_d != state_q) &&
        (state_d == ST_FETCH || state_d == ST_MEM_RD || state_d == ST_MEM_WR)) begin
      wait_cnt_d = '0;
    end

    instr_count_d = instr_count_q + CNT_W'(retire);
  end

  assign ctrl_o = reset ? '0 : ctrl;

  assign bus.mem_read     = ctrl_o.mem_read;
  assign bus.mem_write    = ctrl_o.mem_write;
  assign bus.i_or_d       = ctrl_o.i_or_d;
  assign bus.ir_write     = ctrl_o.ir_write;
  assign bus.pc_write     = ctrl_o.pc_write;
  assign bus.pc_write_beq = ctrl_o.pc_write_beq;
  assign bus.pc_write_bne = ctrl_o.pc_write_bne;
  assign bus.pc_source    = ctrl_o.pc_source;
  assign bus.alu_src_a    = ctrl_o.alu_src_a;
  assign bus.alu_src_b    = ctrl_o.alu_src_b;
  assign bus.alu_op       = ctrl_o.alu_op;
  assign bus.reg_dst      = ctrl_o.reg_dst;
  assign bus.mem_to_reg   = ctrl_o.mem_to_reg;
  assign bus.reg_write    = ctrl_o.reg_write;
  assign bus.halted       = !reset && (state_q == ST_HALT);
  assign bus.halt_cause   = reset ? HALT_NONE : halt_cause_q;
  assign bus.instr_count  = reset ? '0 : instr_count_q;

endmodule
